// File: rtl/fifo_pkg.sv
// Shared definitions for the ingress-FIFO round-robin arbiter.
//   DATA_WIDTH  : word width carried by each ingress FIFO
//   NUM_FIFOS   : number of ingress FIFOs served by the arbiter
//   arb_state_t : arbiter state encoding
package fifo_pkg;

   localparam int unsigned DATA_WIDTH = 6;
   localparam int unsigned NUM_FIFOS  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      PAUSE  = 2'b10,
      ERROR  = 2'b11
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
//   req        : request vector, one bit per FIFO
//   ptr        : last granted index; search starts at ptr+1 (mod 4)
//   gnt_onehot : one-hot grant, zero when no request
//   gnt_idx    : index of the granted request
//   any        : at least one request present
module rr_pick (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt_onehot,
   output logic [1:0] gnt_idx,
   output logic       any
);

   logic [1:0] idx;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      idx        = '0;
      // 2-bit wrap gives the mod-4 rotation for free.
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!any && req[idx]) begin
            any             = 1'b1;
            gnt_idx         = idx;
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin consumer of four ingress FIFOs; forwards each popped word to the
// next-stage FIFO two cycles after its pop.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   fifo_empty  : per-FIFO empty flags (current cycle)
//   fifo_valid  : per-FIFO read-data valid, one cycle after pop
//   fifo_data   : concatenated read data, FIFO i at [i*W +: W]
//   fifo_error  : per-FIFO error flags
//   pausa       : next-stage almost-full, blocks new pops
//   pop         : one-hot or zero read strobe to the ingress FIFOs
//   data_out    : word to the next stage, held while push is low
//   push        : write strobe to the next stage
//   grant_id    : last granted FIFO index
//   active/idle : state decode
//   error_out   : sticky error, cleared only by reset
module fifo_rr_arbiter #(
   parameter int unsigned NUM_FIFOS  = 4,
   parameter int unsigned DATA_WIDTH = 6
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_FIFOS-1:0]            fifo_empty,
   input  logic [NUM_FIFOS-1:0]            fifo_valid,
   input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data,
   input  logic [NUM_FIFOS-1:0]            fifo_error,
   input  logic                            pausa,
   output logic [NUM_FIFOS-1:0]            pop,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic                            push,
   output logic [1:0]                      grant_id,
   output logic                            active,
   output logic                            idle,
   output logic                            error_out
);

   import fifo_pkg::*;

   arb_state_t            state_q, state_d;
   logic [1:0]            rr_ptr_q, grant_q, sel_q;
   logic                  inflight_q;
   logic                  push_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic [3:0] pick_oh;
   logic [1:0] pick_idx;
   logic       pick_any;
   logic       pop_en;
   logic       fwd_valid;
   logic       any_error;
   logic       all_empty;

   rr_pick u_rr_pick (
      .req       (~fifo_empty),
      .ptr       (rr_ptr_q),
      .gnt_onehot(pick_oh),
      .gnt_idx   (pick_idx),
      .any       (pick_any)
   );

   assign any_error = |fifo_error;
   assign all_empty = &fifo_empty;

   // An erroring cycle pops nothing: that word could never be forwarded.
   assign pop_en = (state_q == ACTIVE) && !pausa && !reset && !any_error && pick_any;
   assign pop    = pop_en ? pick_oh : '0;

   // Only the valid of the FIFO popped last cycle counts.
   assign fwd_valid = inflight_q && fifo_valid[sel_q];

   always_comb begin
      state_d = state_q;
      if (any_error) begin
         state_d = ERROR;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!all_empty) state_d = pausa ? PAUSE : ACTIVE;
            end
            ACTIVE: begin
               if (pausa)          state_d = PAUSE;
               else if (all_empty) state_d = IDLE;
            end
            PAUSE: begin
               if (!pausa) state_d = all_empty ? IDLE : ACTIVE;
            end
            ERROR: state_d = ERROR;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 2'd3;
         grant_q    <= 2'd0;
         sel_q      <= 2'd0;
         inflight_q <= 1'b0;
         push_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= pop_en;
         push_q     <= fwd_valid;
         if (pop_en) begin
            rr_ptr_q <= pick_idx;
            grant_q  <= pick_idx;
            sel_q    <= pick_idx;
         end
         if (fwd_valid) begin
            data_q <= fifo_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign data_out  = data_q;
   assign push      = push_q;
   assign grant_id  = grant_q;
   assign active    = (state_q == ACTIVE);
   assign idle      = (state_q == IDLE);
   assign error_out = (state_q == ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  fifo_empty;
   logic [3:0]  fifo_valid;
   logic [23:0] fifo_data;
   logic [3:0]  fifo_error;
   logic        pausa;
   logic [3:0]  pop;
   logic [5:0]  data_out;
   logic        push;
   logic [1:0]  grant_id;
   logic        active;
   logic        idle;
   logic        error_out;

   int n_pass  = 0;
   int n_total = 0;

   fifo_rr_arbiter #(
      .NUM_FIFOS (4),
      .DATA_WIDTH(6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_empty(fifo_empty),
      .fifo_valid(fifo_valid),
      .fifo_data (fifo_data),
      .fifo_error(fifo_error),
      .pausa     (pausa),
      .pop       (pop),
      .data_out  (data_out),
      .push      (push),
      .grant_id  (grant_id),
      .active    (active),
      .idle      (idle),
      .error_out (error_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  emp;
      logic [3:0]  vld;
      logic [23:0] dat;
      logic [3:0]  err;
      logic        pau;
      logic [3:0]  e_pop;
      logic        e_push;
      logic [5:0]  e_dout;
      logic [1:0]  e_gnt;
      logic        e_idle;
      logic        e_act;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [23:0] pk(logic [5:0] a3, logic [5:0] a2, logic [5:0] a1,
                                      logic [5:0] a0);
      return {a3, a2, a1, a0};
   endfunction

   function automatic vec_t mk(logic rst, logic [3:0] emp, logic [3:0] vld, logic [23:0] dat,
                               logic [3:0] err, logic pau, logic [3:0] e_pop, logic e_push,
                               logic [5:0] e_dout, logic [1:0] e_gnt, logic e_idle,
                               logic e_act, logic e_err);
      vec_t v;
      v.rst = rst; v.emp = emp; v.vld = vld; v.dat = dat; v.err = err; v.pau = pau;
      v.e_pop = e_pop; v.e_push = e_push; v.e_dout = e_dout; v.e_gnt = e_gnt;
      v.e_idle = e_idle; v.e_act = e_act; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      else n_pass++;
   endtask

   initial begin
      logic [23:0] d;
      int          waited;
      d = pk(6'h1C, 6'h30, 6'h16, 6'h11);

      // Idle with everything empty
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'hF, 0, d, 0, 0, 0, 0, 6'h00, 0, 1, 0, 0));
      // One entry in each FIFO; row c3 carries a stray valid on FIFO 0
      vecs.push_back(mk(0, 4'h0, 0, d, 0, 0, 4'h0, 0, 6'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, d, 0, 0, 4'h1, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, d, 0, 0, 4'h2, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h3, 4'h3, d, 0, 0, 4'h4, 1, 6'h11, 1, 0, 1, 0));
      vecs.push_back(mk(0, 4'h7, 4'h4, d, 0, 0, 4'h8, 1, 6'h16, 2, 0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h8, d, 0, 0, 4'h0, 1, 6'h30, 3, 0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h0, 1, 6'h1C, 3, 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h0, 0, 6'h1C, 3, 1, 0, 0));
      // Only FIFO 2, three entries
      vecs.push_back(mk(0, 4'hB, 0, d, 0, 0, 4'h0, 0, 6'h1C, 3, 1, 0, 0));
      vecs.push_back(mk(0, 4'hB, 0, d, 0, 0, 4'h4, 0, 6'h1C, 3, 0, 1, 0));
      vecs.push_back(mk(0, 4'hB, 4'h4, pk(6'h1C, 6'h05, 6'h16, 6'h11), 0, 0, 4'h4, 0, 6'h1C, 2,
                        0, 1, 0));
      vecs.push_back(mk(0, 4'hB, 4'h4, pk(6'h1C, 6'h0A, 6'h16, 6'h11), 0, 0, 4'h4, 1, 6'h05, 2,
                        0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h4, pk(6'h1C, 6'h0F, 6'h16, 6'h11), 0, 0, 4'h0, 1, 6'h0A, 2,
                        0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 0, d, 0, 0, 4'h0, 1, 6'h0F, 2, 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, 0, d, 0, 0, 4'h0, 0, 6'h0F, 2, 1, 0, 0));
      // Reset, then all full with pausa after pop[1]
      vecs.push_back(mk(1, 4'hF, 0, d, 0, 0, 4'h0, 0, 6'h0F, 2, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, d, 0, 0, 4'h0, 0, 6'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, d, 0, 0, 4'h1, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h1, d, 0, 0, 4'h2, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h2, d, 0, 1, 4'h0, 1, 6'h11, 1, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 1, 4'h0, 1, 6'h16, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 1, 4'h0, 0, 6'h16, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h0, 0, 6'h16, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h4, 0, 6'h16, 1, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h4, d, 0, 0, 4'h8, 0, 6'h16, 2, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h8, d, 0, 0, 4'h1, 1, 6'h30, 3, 0, 1, 0));
      // Error on FIFO 3 with a word still in flight
      vecs.push_back(mk(0, 4'hF, 4'h1, d, 4'h8, 0, 4'h0, 1, 6'h1C, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h0, 1, 6'h11, 0, 0, 0, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h0, 0, 6'h11, 0, 0, 0, 1));
      vecs.push_back(mk(1, 4'h0, 4'h0, d, 0, 0, 4'h0, 0, 6'h11, 0, 0, 0, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h0, 0, 6'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 0, 4'h1, 0, 6'h00, 0, 0, 1, 0));
      // Reset right after pop[0]: its valid (during and after reset) is dropped
      vecs.push_back(mk(1, 4'h0, 4'h1, d, 0, 0, 4'h0, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h1, d, 0, 0, 4'h0, 0, 6'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h0, 0, 6'h00, 0, 1, 0, 0));

      reset = 1'b1; fifo_empty = 4'hF; fifo_valid = '0; fifo_data = d;
      fifo_error = '0; pausa = 1'b0;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; fifo_empty = vecs[i].emp; fifo_valid = vecs[i].vld;
         fifo_data = vecs[i].dat; fifo_error = vecs[i].err; pausa = vecs[i].pau;
         #1;
         chk($sformatf("row%0d pop", i),       32'(pop),       32'(vecs[i].e_pop));
         chk($sformatf("row%0d push", i),      32'(push),      32'(vecs[i].e_push));
         chk($sformatf("row%0d data_out", i),  32'(data_out),  32'(vecs[i].e_dout));
         chk($sformatf("row%0d grant_id", i),  32'(grant_id),  32'(vecs[i].e_gnt));
         chk($sformatf("row%0d idle", i),      32'(idle),      32'(vecs[i].e_idle));
         chk($sformatf("row%0d active", i),    32'(active),    32'(vecs[i].e_act));
         chk($sformatf("row%0d error_out", i), 32'(error_out), 32'(vecs[i].e_err));
      end

      // FIFO 1 alone with one entry: bounded wait for the pop, then 2-cycle push
      @(negedge clk);
      fifo_empty = 4'hD; fifo_valid = '0;
      waited = 0;
      #1;
      while (pop == 4'h0 && waited < 6) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("solo pop", 32'(pop), 32'h2);
      chk("solo pop wait", 32'(waited), 32'd1);
      @(negedge clk);
      fifo_empty = 4'hF; fifo_valid = 4'h2;
      #1;
      chk("solo pop once", 32'(pop), 32'h0);
      chk("solo grant", 32'(grant_id), 32'd1);
      chk("solo push early", 32'(push), 32'd0);
      @(negedge clk);
      fifo_valid = '0;
      #1;
      chk("solo push", 32'(push), 32'd1);
      chk("solo data", 32'(data_out), 32'h16);
      @(negedge clk);
      #1;
      chk("solo push end", 32'(push), 32'd0);
      chk("solo idle", 32'(idle), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Downstream consumer of the four 6-bit ingress FIFOs.
- Pops the FIFOs in round-robin order and forwards each word to the next-stage FIFO (push + data).
- Honours next-stage backpressure (pausa) and stops on any FIFO error.
- Provides the pop/data_out/push handshake the FIFO block expects on both sides.

Parameters:
- NUM_FIFOS, 4, number of ingress FIFOs; fixed at 4 in this revision (grant_id is 2 bits).
- DATA_WIDTH, 6, word width, matching the FIFO data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  NUM_FIFOS  per-FIFO empty flag; current-cycle, combinational from FIFO state.
- fifo_valid  input  NUM_FIFOS  per-FIFO read-data valid; asserted one cycle after that FIFO's pop.
- fifo_data  input  NUM_FIFOS*DATA_WIDTH  concatenated read data; FIFO i at bits [i*W +: W].
- fifo_error  input  NUM_FIFOS  per-FIFO overflow/underflow error.
- pausa  input  1  next-stage almost-full; no new pops while high.
- pop  output  NUM_FIFOS  one-hot or zero read strobe to the ingress FIFOs.
- data_out  output  DATA_WIDTH  word forwarded to the next stage.
- push  output  1  write strobe to the next stage; qualifies data_out.
- grant_id  output  2  index of the last granted FIFO.
- active  output  1  high in ACTIVE.
- idle  output  1  high in IDLE.
- error_out  output  1  sticky error indication.

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - State goes to IDLE.
  - rr_ptr = 3, so FIFO 0 has first priority.
  - data_out = 0, push = 0, grant_id = 0, error_out = 0, idle = 1, active = 0.
  - pop = 0 while reset is high.
  - Reset asserted mid-operation discards any in-flight word: no push is issued for a FIFO read whose valid arrives during reset or in the cycle after it.
- States: IDLE, ACTIVE, PAUSE, ERROR. State is registered; pop is combinational from state and current inputs.
- Transitions, in priority order (ERROR wins over all others):
  - any state → ERROR when |fifo_error. ERROR is left only by reset.
  - IDLE → ACTIVE when ~&fifo_empty && !pausa.
  - IDLE → PAUSE when ~&fifo_empty && pausa.
  - ACTIVE → PAUSE when pausa.
  - ACTIVE → IDLE when &fifo_empty && !pausa.
  - PAUSE → ACTIVE when !pausa && ~&fifo_empty.
  - PAUSE → IDLE when !pausa && &fifo_empty.
- Pop rule:
  - In ACTIVE with !pausa, search rotating priority from rr_ptr+1 (mod 4) for the first i with !fifo_empty[i].
  - Assert pop[i] only. At the clock edge, rr_ptr ← i and grant_id ← i.
  - At most one pop bit per cycle. No pop in IDLE, PAUSE or ERROR, or while pausa = 1.
  - pausa gates pop in the same cycle it is high (combinational).
- Forwarding:
  - Cycle t: pop[i].
  - Cycle t+1: fifo_valid[i] is high with the data.
  - Cycle t+2: the arbiter registers push = 1 and data_out = fifo_data[i].
  - Latency from pop to push is 2 cycles.
- The arbiter tracks the in-flight index in a register (sel_q). Only fifo_valid[sel_q] is honoured; a valid on any other index is ignored.
- A word already popped is always pushed, even if pausa rises. The next stage's almost-full margin must be ≥ 2.
- Back-to-back pops to the same FIFO are allowed when it is the only non-empty one. Throughput is 1 word/cycle.
- A FIFO holding one entry may be popped once; its empty flag rises the next cycle, so it is not popped again.
- When push = 0, data_out holds its last value.
- ERROR behaviour:
  - error_out = 1 and pop = 0.
  - An in-flight word whose valid arrives in the cycle ERROR is entered is still pushed. No further pushes follow.
- idle and active are a direct decode of the registered state.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH = 6 and NUM_FIFOS = 4.
  - arb_state_t enum {IDLE, ACTIVE, PAUSE, ERROR}, encoded 2'b00..2'b11.
- One sub-module, rr_pick: combinational rotating-priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_onehot[3:0], gnt_idx[1:0], any.

Test Plan:
- Reset, then all fifo_empty = 4'hF for 5 cycles → idle = 1, pop = 0, push = 0, data_out = 6'h00.
- FIFOs 0–3 each non-empty with data 6'h11, 6'h16, 6'h30, 6'h1C, one entry each, pausa = 0:
  - pop sequence is 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles.
  - push with data_out 6'h11, 6'h16, 6'h30, 6'h1C, each 2 cycles after its pop.
  - Afterwards the block returns to IDLE.
- Only FIFO 2 non-empty with 3 entries → pop = 4'b0100 for 3 consecutive cycles; grant_id = 2; three pushes.
- All FIFOs full, pausa raised on the cycle after pop[1]:
  - pop = 0 while pausa is high; the popped word 6'h16 is still pushed.
  - On pausa release, the next pop is pop[2].
- fifo_error[3] pulsed during ACTIVE → next cycle error_out = 1 and pop = 0; the state stays ERROR until reset, after which error_out = 0 and rr_ptr restarts at FIFO 0.
- Reset asserted one cycle after pop[0] → no push is generated for that word; all outputs take their reset values.
